// File: rtl/conv_window_gen_pkg.sv
// Shared types and defaults for the 3x3 convolution window generator.
package conv_window_gen_pkg;

    localparam int unsigned DATA_W_DFLT = 8;
    localparam int unsigned WIN_N       = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixel storage: single address, write on the rising edge,
// read data reflects the addressed entry (address is a register upstream).
module line_buffer #(
    parameter int unsigned DEPTH  = 28,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are not reset: every entry is rewritten before it reaches a window.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// Streams a raster frame in and emits every fully-populated 3x3 window with
// valid/ready flow control on both sides.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      win_valid,
    output logic [WIN_N*DATA_W-1:0]   win_data,
    input  logic                      win_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_e                          state_q, state_d;
    logic [COL_W-1:0]                col_q, col_d;
    logic [ROW_W-1:0]                row_q, row_d;
    logic                            all_in_q, all_in_d;
    logic                            win_valid_q, win_valid_d;
    logic [WIN_N-1:0][DATA_W-1:0]    win_q, win_d;
    logic                            busy_q, done_q;
    logic                            px_fire, win_fire, last_col, last_px;
    logic [DATA_W-1:0]               row1_rd, row2_rd;

    // in_ready looks at win_ready so a full pipeline can still accept when draining.
    assign in_ready  = (state_q == ST_RUN) && !all_in_q && (!win_valid_q || win_ready);
    assign px_fire   = in_valid && in_ready;
    assign win_fire  = win_valid_q && win_ready;
    assign last_col  = (col_q == COL_W'(IMG_W - 1));
    assign last_px   = last_col && (row_q == ROW_W'(IMG_H - 1));

    assign win_valid = win_valid_q;
    assign win_data  = win_q;
    assign busy      = busy_q;
    assign done      = done_q;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_lb_row1 (
        .clk     (clk),
        .we_i    (px_fire),
        .addr_i  (col_q),
        .wdata_i (in_data),
        .rdata_o (row1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_lb_row2 (
        .clk     (clk),
        .we_i    (px_fire),
        .addr_i  (col_q),
        .wdata_i (row1_rd),
        .rdata_o (row2_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            all_in_q    <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            all_in_q    <= all_in_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_FIN);
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        all_in_d    = all_in_q;
        win_valid_d = win_valid_q;
        win_d       = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    col_d       = '0;
                    row_d       = '0;
                    all_in_d    = 1'b0;
                    win_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (win_fire) begin
                    win_valid_d = 1'b0;
                end
                if (px_fire) begin
                    // Shift one column left; new right column is {row-2, row-1, pixel}.
                    for (int r = 0; r < 3; r++) begin
                        win_d[3*r]     = win_q[3*r + 1];
                        win_d[3*r + 1] = win_q[3*r + 2];
                    end
                    win_d[2] = row2_rd;
                    win_d[5] = row1_rd;
                    win_d[8] = in_data;

                    if (row_q >= ROW_W'(2) && col_q >= COL_W'(2)) begin
                        win_valid_d = 1'b1;
                    end
                    if (last_col) begin
                        col_d = '0;
                        row_d = last_px ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_px) begin
                        all_in_d = 1'b1;
                    end
                end
                // Once every pixel is in, the only pending window is the last one.
                if (win_fire && all_in_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
